// File: rtl/ml_qspi_target.sv
// ml_qspi_target: 4-bit MARLANN host link responder.
// Oversamples csb/clk/io, emits rx bytes, drives io for core tx bytes.
// Ports: clock, reset | ml_csb, ml_clk, ml_io_di -> ml_io_do, ml_io_oe
//        rx_valid/rx_data/rx_first, tx_valid/tx_data/tx_ready,
//        xfer_active, xfer_end, frame_err.
module ml_qspi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ml_csb,
  input  logic       ml_clk,
  input  logic [3:0] ml_io_di,
  output logic [3:0] ml_io_do,
  output logic [3:0] ml_io_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       xfer_active,
  output logic       xfer_end,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_HI, S_LO
  } state_t;

  logic [SYNC_STAGES-1:0]      r_csb_s;
  logic [SYNC_STAGES-1:0]      r_clk_s;
  logic [SYNC_STAGES-1:0][3:0] r_io_s;
  logic [SYNC_STAGES-1:0]      r_vld;
  logic                        r_clk_d;
  logic [3:0]                  r_io_d;
  logic                        r_armed;

  logic       w_csb;
  logic       w_clk;
  logic [3:0] w_io;
  logic       w_fall;
  logic       w_rise;

  assign w_csb  = r_csb_s[SYNC_STAGES-1];
  assign w_clk  = r_clk_s[SYNC_STAGES-1];
  assign w_io   = r_io_s[SYNC_STAGES-1];
  assign w_fall = r_clk_d & ~w_clk;
  assign w_rise = ~r_clk_d & w_clk;

  // r_vld tracks when the sync chain holds post-reset pad samples, so
  // the reset value of csb cannot fake a fall; r_armed needs a real high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_csb_s <= '1;
      r_clk_s <= '1;
      r_io_s  <= '0;
      r_vld   <= '0;
      r_clk_d <= 1'b1;
      r_io_d  <= 4'h0;
      r_armed <= 1'b0;
    end else begin
      r_csb_s <= {r_csb_s[SYNC_STAGES-2:0], ml_csb};
      r_clk_s <= {r_clk_s[SYNC_STAGES-2:0], ml_clk};
      r_io_s  <= {r_io_s[SYNC_STAGES-2:0], ml_io_di};
      r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_clk_d <= w_clk;
      r_io_d  <= w_io;
      r_armed <= r_armed | (r_vld[SYNC_STAGES-1] & w_csb);
    end
  end

  state_t     r_state, w_state_n;
  logic       r_first, w_first_n;
  logic       r_send, w_send_n;
  logic [3:0] r_shreg, w_shreg_n;
  logic [3:0] r_txbuf, w_txbuf_n;
  logic [3:0] r_do, w_do_n;
  logic       r_oe, w_oe_n;
  logic [7:0] r_rx_data, w_rx_data_n;
  logic       r_rx_valid, w_rx_valid_n;
  logic       r_rx_first, w_rx_first_n;
  logic       r_tx_ready, w_tx_ready_n;
  logic       r_xfer_end, w_xfer_end_n;
  logic       r_frame_err, w_frame_err_n;
  logic       r_xfer_active;
  logic       w_start;

  always_comb begin
    w_state_n     = r_state;
    w_first_n     = r_first;
    w_send_n      = r_send;
    w_shreg_n     = r_shreg;
    w_txbuf_n     = r_txbuf;
    w_do_n        = r_do;
    w_oe_n        = r_oe;
    w_rx_data_n   = r_rx_data;
    w_rx_valid_n  = 1'b0;
    w_rx_first_n  = 1'b0;
    w_tx_ready_n  = 1'b0;
    w_xfer_end_n  = 1'b0;
    w_frame_err_n = 1'b0;
    w_start       = 1'b0;
    if (w_csb) begin
      // csb wins over any same-cycle clk edge; partial byte dropped
      if (r_state != S_IDLE) begin
        w_state_n     = S_IDLE;
        w_oe_n        = 1'b0;
        w_xfer_end_n  = 1'b1;
        w_frame_err_n = (r_state == S_LO);
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_armed) begin
            w_state_n = S_START;
            w_first_n = 1'b1;
          end
        end
        S_START: w_start = w_fall;
        S_HI: begin
          if (w_rise) begin
            w_state_n = S_LO;
            if (r_send) w_do_n = r_txbuf;
            else w_shreg_n = r_io_d;
          end
        end
        S_LO: begin
          if (w_fall) begin
            w_start = 1'b1;
            if (!r_send) begin
              w_rx_data_n  = {r_shreg, r_io_d};
              w_rx_valid_n = 1'b1;
              w_rx_first_n = r_first;
              w_first_n    = 1'b0;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
      if (w_start) begin
        w_state_n = S_HI;
        w_send_n  = tx_valid;
        w_oe_n    = tx_valid;
        if (tx_valid) begin
          w_txbuf_n    = tx_data[3:0];
          w_do_n       = tx_data[7:4];
          w_tx_ready_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_first       <= 1'b0;
      r_send        <= 1'b0;
      r_shreg       <= 4'h0;
      r_txbuf       <= 4'h0;
      r_do          <= 4'h0;
      r_oe          <= 1'b0;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_rx_first    <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_xfer_end    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_xfer_active <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_first       <= w_first_n;
      r_send        <= w_send_n;
      r_shreg       <= w_shreg_n;
      r_txbuf       <= w_txbuf_n;
      r_do          <= w_do_n;
      r_oe          <= w_oe_n;
      r_rx_data     <= w_rx_data_n;
      r_rx_valid    <= w_rx_valid_n;
      r_rx_first    <= w_rx_first_n;
      r_tx_ready    <= w_tx_ready_n;
      r_xfer_end    <= w_xfer_end_n;
      r_frame_err   <= w_frame_err_n;
      r_xfer_active <= ~w_csb;
    end
  end

  assign ml_io_do    = r_do;
  assign ml_io_oe    = {4{r_oe}};
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_first    = r_rx_first;
  assign tx_ready    = r_tx_ready;
  assign xfer_active = r_xfer_active;
  assign xfer_end    = r_xfer_end;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ml_qspi_target.sv
// tb_ml_qspi_target: randomized host-link bench with a scoreboard.
// Host tasks push expected bytes/ends; a monitor pops and compares.
module tb_ml_qspi_target;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ml_csb = 1'b1;
  logic       ml_clk = 1'b1;
  logic [3:0] ml_io_di = 4'h0;
  logic [3:0] ml_io_do;
  logic [3:0] ml_io_oe;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       xfer_active;
  logic       xfer_end;
  logic       frame_err;

  ml_qspi_target dut (
    .clock(clock), .reset(reset),
    .ml_csb(ml_csb), .ml_clk(ml_clk),
    .ml_io_di(ml_io_di), .ml_io_do(ml_io_do),
    .ml_io_oe(ml_io_oe),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_first(rx_first),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready),
    .xfer_active(xfer_active),
    .xfer_end(xfer_end), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // expected: {first, data}; expected transaction ends: abort flag
  logic [8:0] exp_rx[$];
  bit         exp_end[$];
  int         exp_tx = 0;

  logic [7:0] t_d[$];
  bit         t_rd[$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_stray got=%02h", rx_data);
        end else begin
          logic [8:0] e;
          e = exp_rx.pop_front();
          if (rx_data !== e[7:0] || rx_first !== e[8]) begin
            errors++;
            $display("FAIL rx got=%02h/%0b exp=%02h/%0b",
                     rx_data, rx_first, e[7:0], e[8]);
          end
        end
      end
      if (tx_ready) begin
        checks++;
        if (exp_tx == 0) begin
          errors++;
          $display("FAIL tx_ready_stray got=1 exp=0");
        end else exp_tx--;
      end
      if (xfer_end) begin
        checks++;
        if (exp_end.size() == 0) begin
          errors++;
          $display("FAIL xfer_end_stray got=1 exp=0");
        end else begin
          bit a;
          a = exp_end.pop_front();
          if (frame_err !== a) begin
            errors++;
            $display("FAIL frame_err got=%0b exp=%0b", frame_err, a);
          end
        end
      end else if (frame_err) begin
        checks++;
        errors++;
        $display("FAIL frame_err_stray got=1 exp=0");
      end
    end
  end

  // One host transaction from t_d/t_rd; abort drops csb mid last byte.
  task automatic xact(input bit abort);
    bit first;
    int n;
    n = t_d.size();
    first = 1'b1;
    ml_csb = 1'b0;
    cyc(6);
    for (int i = 0; i < n; i++) begin
      if (t_rd[i]) begin
        tx_valid = 1'b1;
        tx_data  = t_d[i];
        exp_tx++;
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      ml_clk   = 1'b0;
      ml_io_di = t_d[i][7:4];
      cyc(7);
      if (t_rd[i]) begin
        chk("rd_oe_hi", {4'h0, ml_io_oe}, 8'h0F);
        chk("rd_do_hi", {4'h0, ml_io_do}, {4'h0, t_d[i][7:4]});
      end else begin
        chk("wr_oe", {4'h0, ml_io_oe}, 8'h00);
      end
      cyc(1);
      tx_valid = 1'b0;
      ml_clk   = 1'b1;
      ml_io_di = t_d[i][3:0];
      cyc(7);
      if (t_rd[i])
        chk("rd_do_lo", {4'h0, ml_io_do}, {4'h0, t_d[i][3:0]});
      cyc(1);
      if (!t_rd[i] && !(abort && i == n - 1)) begin
        exp_rx.push_back({first, t_d[i]});
        first = 1'b0;
      end
    end
    chk("active", {7'h0, xfer_active}, 8'h01);
    if (!abort) begin
      tx_valid = 1'b0;
      ml_clk   = 1'b0;
      ml_io_di = 4'($urandom);
      cyc(8);
      chk("end_oe", {4'h0, ml_io_oe}, 8'h00);
    end
    ml_csb = 1'b1;
    exp_end.push_back(abort);
    cyc(6);
    chk("idle_oe", {4'h0, ml_io_oe}, 8'h00);
    chk("idle_act", {7'h0, xfer_active}, 8'h00);
    ml_clk = 1'b1;
    cyc(6);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL timeout got=running exp=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    cyc(3);
    chk("rst_oe", {4'h0, ml_io_oe}, 8'h00);
    chk("rst_do", {4'h0, ml_io_do}, 8'h00);
    chk("rst_rxd", rx_data, 8'h00);
    chk("rst_pulses",
        {4'h0, rx_valid, tx_ready, xfer_end, frame_err}, 8'h00);
    reset = 1'b0;
    cyc(6);

    t_d = '{8'hA5}; t_rd = '{1'b0};
    xact(1'b0);
    for (int i = 0; i < 32; i++) begin
      t_d = '{8'(i)}; t_rd = '{1'b0};
      xact(1'b0);
    end
    t_d = '{8'h12, 8'h34, 8'h56}; t_rd = '{1'b0, 1'b0, 1'b0};
    xact(1'b0);
    t_d = '{8'h0B, 8'h3C}; t_rd = '{1'b0, 1'b1};
    xact(1'b0);
    t_d = '{8'h70}; t_rd = '{1'b0};
    xact(1'b1);

    for (int k = 0; k < 30; k++) begin
      int n;
      n = int'($urandom_range(1, 4));
      t_d.delete(); t_rd.delete();
      for (int j = 0; j < n; j++) begin
        t_d.push_back(8'($urandom));
        t_rd.push_back($urandom_range(0, 2) == 0);
      end
      xact($urandom_range(0, 4) == 0);
    end

    // reset in the middle of a send byte
    ml_csb = 1'b0;
    cyc(6);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    exp_tx++;
    ml_clk = 1'b0;
    cyc(6);
    chk("mid_oe", {4'h0, ml_io_oe}, 8'h0F);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_oe", {4'h0, ml_io_oe}, 8'h00);
    chk("arst_do", {4'h0, ml_io_do}, 8'h00);
    chk("arst_rxd", rx_data, 8'h00);
    tx_valid = 1'b0;
    cyc(3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ml_clk = 1'b1; ml_io_di = 4'h9; cyc(8);
      ml_clk = 1'b0; ml_io_di = 4'h6; cyc(8);
    end
    chk("post_rst_oe", {4'h0, ml_io_oe}, 8'h00);
    ml_csb = 1'b1;
    cyc(6);
    ml_clk = 1'b1;
    cyc(6);
    t_d = '{8'hC3, 8'h81}; t_rd = '{1'b0, 1'b0};
    xact(1'b0);

    cyc(10);
    chk("rx_left", 8'(exp_rx.size()), 8'h00);
    chk("end_left", 8'(exp_end.size()), 8'h00);
    chk("tx_left", 8'(exp_tx), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ml_qspi_target.md
# ml_qspi_target

Device-side responder for the 4-bit MARLANN host link (`ml_csb`, `ml_clk`, `ml_io0..3`). It oversamples the host-driven link in the `clock` domain, turns each nibble pair into a byte for the core, and drives the I/O lines when the core supplies read data. It sits directly behind the `top` pads: the tristate buffers stay in `top`, and the byte stream feeds the command decoder.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `ml_csb`, `ml_clk` and `ml_io_di`; legal values 2..3.

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ml_csb` in 1: host chip select, active low.
- `ml_clk` in 1: host link clock; idles high.
- `ml_io_di` in 4: pad inputs {io3,io2,io1,io0}.
- `ml_io_do` out 4: pad output data.
- `ml_io_oe` out 4: pad output enables; all four bits always equal.
- `rx_valid` out 1: one-cycle pulse, received byte on `rx_data`.
- `rx_data` out 8: received byte; held until the next `rx_valid`.
- `rx_first` out 1: qualifies `rx_valid`; the byte is the first of the transaction.
- `tx_valid` in 1: core has a byte to send.
- `tx_data` in 8: byte to send.
- `tx_ready` out 1: one-cycle pulse, `tx_data` was consumed.
- `xfer_active` out 1: synchronized `ml_csb` is low.
- `xfer_end` out 1: one-cycle pulse on synchronized `ml_csb` rising.
- `frame_err` out 1: one-cycle pulse; `ml_csb` rose mid-byte.

## Operation
- **Link format:** MSB nibble first, on io3..io0.
  - The host puts the high nibble on the lines with `ml_clk` falling.
  - It puts the low nibble on the lines with `ml_clk` rising.
  - The next falling edge ends the byte.
- **Input pipeline:** all inputs pass through `SYNC_STAGES` flops. An edge is detected by comparing the last stage with a one-cycle-delayed copy.
- **Input sampling:** input nibbles are captured from the delayed copy of `ml_io_di`, i.e. the value present while `ml_clk` was still at its previous level. Lines that change together with `ml_clk` are therefore sampled correctly.
- **FSM states:** IDLE, START, HI, LO.
  - IDLE → START when synchronized `ml_csb` falls; sets `first`.
  - START → HI on the `ml_clk` fall. This is a byte start.
  - HI → LO on the `ml_clk` rise:
    - receive byte: `shreg[7:4]` = sampled io;
    - send byte: `ml_io_do` = `txbuf[3:0]`.
  - LO → HI on the `ml_clk` fall. The byte ends and the next byte starts:
    - receive byte: `rx_data` = {`shreg[7:4]`, sampled io}, pulse `rx_valid`, `rx_first` = `first`, then clear `first`;
    - send byte: no rx pulse.
  - Any state → IDLE when synchronized `ml_csb` is high. In this transition: `oe`=0, pulse `xfer_end`, and pulse `frame_err` if the state was LO.
  - In the same transition, a partial byte is discarded, with no `rx_valid`. A byte that completed on an earlier fall is already delivered.
- **Byte-start rule:** evaluated on every START→HI or LO→HI fall.
  - `tx_valid`=1: send byte. Latch `txbuf`=`tx_data`, pulse `tx_ready`, `ml_io_do`=`tx_data[7:4]`, `oe`=1.
  - `tx_valid`=0: receive byte, `oe`=0.
- **Simultaneous events:**
  - `ml_csb` rise in the same cycle as a clk edge: `ml_csb` wins.
  - `ml_clk` edges while IDLE are ignored.
- **Reset:** asynchronous, in any state, mid-byte included.
  - Goes to IDLE with `oe`=0, `do`=0 and `rx_data`=0.
  - All pulse outputs and `xfer_active`=0; synchronizers reset to `ml_csb`=1, `ml_clk`=1.
  - The first transaction after reset begins only on a fresh `ml_csb` fall.

## Timing
- **Edge-to-output latency:** SYNC_STAGES+1 `clock` cycles from an `ml_clk` pad edge to `rx_valid`, `tx_ready` and `ml_io_do`/`ml_io_oe` updates. That is 3 cycles at the default.
- **Link rate:** `ml_clk` high and low times must each be ≥ SYNC_STAGES+3 cycles. Host read sampling must occur ≥ SYNC_STAGES+2 cycles after its edge.
- **`tx_valid` setup:** must be stable by the cycle in which the byte-start fall is detected. Change it only after `tx_ready`.
- **Back-to-back send:** 0 bubble. `oe` stays 1 across a send→send boundary.
- **Send→receive boundary:** `oe` drops in the same cycle `do` would have updated.
- **`xfer_end`:** SYNC_STAGES+1 cycles after the `ml_csb` pad rise.
- **`ml_csb` hold:** must stay high ≥ SYNC_STAGES+2 cycles between transactions.
- **All outputs are registered.**

## Test plan
- **Single byte:** csb low, send 0xA5 (hi 0xA, lo 0x5), csb high → one `rx_valid`, `rx_data`=0xA5, `rx_first`=1, one `xfer_end`, no `frame_err`.
- **Indices 0..31:** 32 single-byte transactions, bytes 0x00..0x1F → 32 `rx_valid`, each with `rx_first`=1, data equal to the index.
- **Multi-byte:** 0x12, 0x34, 0x56 in one transaction → 3 `rx_valid`; `rx_first` only on 0x12.
- **Read:** after 0x0B is received, core holds `tx_valid`=1, `tx_data`=0x3C.
  - Host reads 0x3: `oe`=1 from the fall; `tx_ready` once.
  - Host reads 0xC after the rise.
  - Next fall with `tx_valid`=0 → `oe`=0.
- **Abort:** csb rises after the high nibble 0x7 only → no `rx_valid`, `frame_err`=1 for one cycle, `oe`=0.
- **Reset:** assert `reset` mid-send with `oe`=1 → `oe`=0 and IDLE immediately. Clock edges with csb still low produce nothing until csb cycles high→low.
